load_store_unit: RTL

- Memory-access stage logic; consumes ALUResultM and WriteDataM from the E/M pipeline register.
- Drives the data-memory bus through a req/ready handshake, with byte/half/word alignment and sign/zero extension.
- Returns ReadDataM to the M/W pipeline register.
- Raises StallM to the hazard unit so that F/D/E/M hold while an access is outstanding.

---
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
//   mem_req   : request, held until the access completes or times out
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word-aligned byte address
//   mem_wdata : store data, replicated across the byte lanes
//   mem_be    : byte enables
//   mem_rdata : read data returned by memory
//   mem_ready : memory completes the request in this cycle
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit. Takes the effective address and store data
// from the E/M register, runs one req/ready transaction on the data bus per
// legal access and returns the aligned, extended load result.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   MemReadM, MemWriteM   : load / store in M
//   Funct3M               : RV32I access size and signedness
//   ALUResultM            : effective byte address
//   WriteDataM            : store source
//   bus                   : data-memory bus (master side)
//   ReadDataM             : extended load data, valid in DONE, 0 otherwise
//   StallM                : holds F/D/E/M while an access is in flight
//   MisalignM             : illegal or misaligned access (combinational)
//   BusErrM               : access timed out, valid in DONE
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    load_store_unit_if.master     bus,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  MisalignM,
    output logic                  BusErrM
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [31:0]       mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic [3:0]        mem_be_r;
    logic [2:0]        funct3_r;
    logic [1:0]        offset_r;
    logic [31:0]       read_data_r;
    logic              bus_err_r;

    logic              access_s;
    logic              legal_s;
    logic              start_s;
    logic              misalign_s;
    logic [31:0]       wdata_s;
    logic [3:0]        be_s;

    // Exactly one of read/write, a supported funct3 and natural alignment.
    function automatic logic access_legal(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] a);
        logic ld;
        logic st;
        logic ok;
        ld = rd & ~wr;
        st = wr & ~rd;
        case (f3)
            3'b000:  ok = ld | st;
            3'b001:  ok = (ld | st) & ~a[0];
            3'b010:  ok = (ld | st) & (a == 2'b00);
            3'b100:  ok = ld;
            3'b101:  ok = ld & ~a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Pick the addressed byte/half out of the bus word and extend it.
    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] offs,
                                                input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = rdata >> {offs, 3'b000};
        b       = shifted[7:0];
        h       = offs[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  format_load = {{24{b[7]}}, b};
            3'b001:  format_load = {{16{h[15]}}, h};
            3'b100:  format_load = {24'h000000, b};
            3'b101:  format_load = {16'h0000, h};
            default: format_load = rdata;
        endcase
    endfunction

    // Legality, start and stall decode; nothing is reported while reset is held.
    always_comb begin
        access_s = MemReadM | MemWriteM;
        legal_s  = access_legal(MemReadM, MemWriteM, Funct3M, ALUResultM[1:0]);
        if (reset && (state_r == IDLE)) begin
            start_s    = access_s & legal_s;
            misalign_s = access_s & ~legal_s;
        end else begin
            start_s    = 1'b0;
            misalign_s = 1'b0;
        end
        if (reset && (state_r == BUSY)) begin
            StallM = 1'b1;
        end else begin
            StallM = start_s;
        end
        MisalignM = misalign_s;
    end

    // Store lane replication and byte enables; loads read the whole word.
    always_comb begin
        wdata_s = WriteDataM;
        be_s    = 4'b1111;
        if (MemWriteM) begin
            case (Funct3M[1:0])
                2'b00: begin
                    wdata_s = {4{WriteDataM[7:0]}};
                    be_s    = 4'b0001 << ALUResultM[1:0];
                end
                2'b01: begin
                    wdata_s = {2{WriteDataM[15:0]}};
                    be_s    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_s = WriteDataM;
                    be_s    = 4'b1111;
                end
            endcase
        end else begin
            wdata_s = WriteDataM;
            be_s    = 4'b1111;
        end
    end

    // Access FSM with registered bus outputs, load result and timeout counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            wait_cnt_r  <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            funct3_r    <= 3'b000;
            offset_r    <= 2'b00;
            read_data_r <= 32'h0000_0000;
            bus_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    wait_cnt_r  <= '0;
                    read_data_r <= 32'h0000_0000;
                    bus_err_r   <= 1'b0;
                    if (start_s) begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= MemWriteM;
                        mem_addr_r  <= {ALUResultM[31:2], 2'b00};
                        mem_wdata_r <= wdata_s;
                        mem_be_r    <= be_s;
                        funct3_r    <= Funct3M;
                        offset_r    <= ALUResultM[1:0];
                        state_r     <= BUSY;
                    end else begin
                        mem_req_r   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        mem_req_r   <= 1'b0;
                        read_data_r <= mem_we_r ? 32'h0000_0000
                                                : format_load(funct3_r, offset_r, bus.mem_rdata);
                        state_r     <= DONE;
                    end else if (wait_cnt_r == LAST_WAIT) begin
                        // The final allowed BUSY cycle passed without ready.
                        mem_req_r   <= 1'b0;
                        bus_err_r   <= 1'b1;
                        read_data_r <= 32'h0000_0000;
                        state_r     <= DONE;
                    end else begin
                        wait_cnt_r  <= wait_cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Result is consumed at this edge; clear it so IDLE shows 0.
                    state_r     <= IDLE;
                    bus_err_r   <= 1'b0;
                    wait_cnt_r  <= '0;
                    read_data_r <= 32'h0000_0000;
                    mem_req_r   <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    mem_req_r   <= 1'b0;
                    wait_cnt_r  <= '0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_be    = mem_be_r;
    assign ReadDataM     = read_data_r;
    assign BusErrM       = bus_err_r;

endmodule
